// File: rtl/uart_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_responder
// Description : Byte-level register-access responder behind a UART FIFO pair.
//               It parses 'W' addr data and 'R' addr frames from the receive
//               FIFO and runs them against a local 8-bit register bank. It
//               then pushes one ACK, NAK or read-data byte per frame into the
//               transmit FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_responder #(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_empty,
  input  logic [7:0]            r_data,
  output logic                  rd_uart,
  input  logic                  tx_full,
  output logic [7:0]            w_data,
  output logic                  wr_uart,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  frame_err
);

  localparam logic [2:0]  c_ST_IDLE     = 3'd0;
  localparam logic [2:0]  c_ST_GET_ADDR = 3'd1;
  localparam logic [2:0]  c_ST_GET_DATA = 3'd2;
  localparam logic [2:0]  c_ST_EXEC     = 3'd3;
  localparam logic [2:0]  c_ST_SEND     = 3'd4;

  localparam logic [7:0]  c_CMD_W = 8'h57;
  localparam logic [7:0]  c_CMD_R = 8'h52;
  localparam logic [7:0]  c_ACK   = 8'h06;
  localparam logic [7:0]  c_NAK   = 8'h15;

  // The timeout fires on the empty cycle in which the counter would reach
  // TIMEOUT_CYCLES-1, i.e. after TIMEOUT_CYCLES-1 consecutive empty cycles.
  localparam logic [15:0] c_TOUT_LAST = 16'(TIMEOUT_CYCLES - 2);
  // One extra bit so that NUM_REGS = 256 compares correctly.
  localparam logic [8:0]  c_NUM_REGS  = 9'(NUM_REGS);

  logic [2:0]  state_q, state_d;
  logic [15:0] tout_q, tout_d;
  logic [7:0]  cmd_q, addr_q, data_q;
  logic [7:0]  w_data_q;
  logic        frame_err_q;
  logic [7:0]  regs_q [NUM_REGS];

  logic        pop, push, exec, in_frame, tout_hit;
  logic        cmd_ok, addr_ok, is_nak, wr_en;
  logic [7:0]  rd_val, resp;

  // FSM state register and inter-byte timeout counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= c_ST_IDLE;
      tout_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state logic; the counter only advances while waiting inside a frame
  always_comb begin
    state_d = state_q;
    tout_d  = 16'd0;
    case (state_q)
      c_ST_IDLE: begin
        if (pop) begin
          if (r_data == c_CMD_W || r_data == c_CMD_R) state_d = c_ST_GET_ADDR;
          else                                        state_d = c_ST_EXEC;
        end
      end
      c_ST_GET_ADDR: begin
        if (pop) begin
          state_d = (cmd_q == c_CMD_W) ? c_ST_GET_DATA : c_ST_EXEC;
        end else if (tout_hit) begin
          state_d = c_ST_IDLE;
        end else begin
          tout_d = tout_q + 16'd1;
        end
      end
      c_ST_GET_DATA: begin
        if (pop) begin
          state_d = c_ST_EXEC;
        end else if (tout_hit) begin
          state_d = c_ST_IDLE;
        end else begin
          tout_d = tout_q + 16'd1;
        end
      end
      c_ST_EXEC: state_d = c_ST_SEND;
      c_ST_SEND: begin
        if (!tx_full) state_d = c_ST_IDLE;
      end
      default:   state_d = c_ST_IDLE;
    endcase
  end

  // FSM outputs: FIFO strobes, execute strobe and timeout detection
  always_comb begin
    in_frame = (state_q == c_ST_GET_ADDR) || (state_q == c_ST_GET_DATA);
    pop      = reset_n && !rx_empty &&
               ((state_q == c_ST_IDLE) || in_frame);
    push     = reset_n && !tx_full && (state_q == c_ST_SEND);
    exec     = (state_q == c_ST_EXEC);
    tout_hit = in_frame && rx_empty && (tout_q == c_TOUT_LAST);
  end

  // Frame decode: full 8-bit address compared against the bank size
  always_comb begin
    cmd_ok  = (cmd_q == c_CMD_W) || (cmd_q == c_CMD_R);
    addr_ok = ({1'b0, addr_q} < c_NUM_REGS);
    is_nak  = !cmd_ok || !addr_ok;
    wr_en   = exec && !is_nak && (cmd_q == c_CMD_W);
    rd_val  = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == 8'(i)) rd_val = regs_q[i];
    end
    if (is_nak)                  resp = c_NAK;
    else if (cmd_q == c_CMD_W)   resp = c_ACK;
    else                         resp = rd_val;
  end

  // Capture frame bytes on their pop edge, load response and error pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_q       <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      w_data_q    <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= (exec && is_nak) || tout_hit;
      if (pop && state_q == c_ST_IDLE)     cmd_q  <= r_data;
      if (pop && state_q == c_ST_GET_ADDR) addr_q <= r_data;
      if (pop && state_q == c_ST_GET_DATA) data_q <= r_data;
      if (exec)                            w_data_q <= resp;
    end
  end

  // Register bank; each register loads only on a valid write to its address
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [7:0] c_IDX = 8'(gi);
    always_ff @(posedge clk) begin
      if (!reset_n)                        regs_q[gi] <= 8'h00;
      else if (wr_en && addr_q == c_IDX)   regs_q[gi] <= data_q;
    end
    assign regs_flat[8*gi +: 8] = regs_q[gi];
  end

  assign rd_uart   = pop;
  assign wr_uart   = push;
  assign w_data    = w_data_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: doc/uart_reg_responder.md
# uart_reg_responder

Byte-level register-access responder on the host side of `uart`. It pops command frames from the UART receive FIFO, executes reads and writes against a local register bank, and pushes one response byte per frame into the UART transmit FIFO. It is the responding end of the byte stream that a host or testbench initiates through `uart`'s `w_data`/`wr_uart` path.

## Interface
Parameters:
- `NUM_REGS`, 16: number of 8-bit registers; valid addresses are 0..NUM_REGS-1, NUM_REGS ≤ 256.
- `TIMEOUT_CYCLES`, 20000: maximum idle cycles between bytes of one frame; 2..65535; 16-bit counter.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `rx_empty`  in  1  from `uart`; receive FIFO empty.
- `r_data`  in  8  from `uart`; head of receive FIFO, first-word-fall-through, valid when `rx_empty`=0.
- `rd_uart`  out  1  pop strobe to receive FIFO.
- `tx_full`  in  1  from `uart`; transmit FIFO full.
- `w_data`  out  8  response byte to transmit FIFO.
- `wr_uart`  out  1  push strobe to transmit FIFO.
- `regs_flat`  out  8*NUM_REGS  register bank; reg i at bits [8i+7:8i].
- `frame_err`  out  1  one-cycle pulse on NAK or timeout.

## Operation
Frame formats, in byte order:
- Write: 0x57 ('W'), addr, data. Response: 0x06 (ACK), or 0x15 (NAK) if addr ≥ NUM_REGS. The register is not modified on NAK.
- Read: 0x52 ('R'), addr. Response: reg[addr], or 0x15 (NAK) if addr ≥ NUM_REGS.
- Any other first byte: popped, NAK sent, return to IDLE.

FSM states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND.
- IDLE: on a pop, latch the command byte.
  - 'W' or 'R' → GET_ADDR.
  - Otherwise → EXEC with a NAK pending.
- GET_ADDR: on a pop, latch addr.
  - 'W' → GET_DATA.
  - 'R' → EXEC.
- GET_DATA: on a pop, latch data → EXEC.
- EXEC: one cycle.
  - Perform the write if valid.
  - Load the response register (`w_data`).
  - Pulse `frame_err` if NAK.
  - → SEND.
- SEND: `wr_uart` = 1 while `tx_full`=0; that edge → IDLE. Stay in SEND while `tx_full`=1.

Strobes and counters:
- `rd_uart` = reset_n & ~rx_empty & (state ∈ {IDLE, GET_ADDR, GET_DATA}), combinational.
- `r_data` is captured on the same edge as the pop. At most one byte per cycle.
- `wr_uart` = reset_n & ~tx_full & (state == SEND), combinational. Exactly one push per frame.
- Timeout counter runs only in GET_ADDR/GET_DATA.
  - Cleared on every pop and on entry to those states.
  - Increments each cycle with `rx_empty`=1.
  - At TIMEOUT_CYCLES-1 → IDLE: partial frame discarded, `frame_err` pulse, no response byte.

## Timing
- While `reset_n`=0, at each clock edge:
  - State becomes IDLE.
  - All registers become 0x00.
  - `w_data` becomes 0x00.
  - Timeout counter becomes 0.
  - `frame_err` becomes 0.
- `rd_uart`/`wr_uart` are forced 0 while `reset_n`=0.
- Reset mid-frame drops the frame and any pending response. Bytes left in the FIFO are parsed fresh as new frames after reset.
- Write frame, bytes available back-to-back:
  - Pops at edges N, N+1, N+2.
  - EXEC in the following cycle.
  - Register and `w_data` updated at edge N+3.
  - `wr_uart` high in cycle N+3..N+4 if `tx_full`=0.
- Read frame: pops at N, N+1; `w_data` = reg[addr] at edge N+2; push in the next cycle.
- The read response reflects the register value at the EXEC edge, including a write from the immediately preceding frame.
- No pops while in EXEC/SEND. Receive bytes stay in the FIFO; backpressure comes only from `tx_full`.
- `frame_err` is high for exactly the cycle after the EXEC edge (NAK) or after the timeout edge.
- Address compare uses the full 8-bit addr against NUM_REGS.

## Test plan
- Write 'W',0x03,0xA5 → one ACK 0x06 pushed; `regs_flat`[31:24]=0xA5; all other registers 0x00; `frame_err` never pulses.
- Preceding write followed by 'R',0x03 → `w_data`=0xA5 with a single `wr_uart` pulse. Then 'R',0x0F on a fresh reset → 0x00.
- Out-of-range and invalid commands → NAK 0x15 each, no register change, one `frame_err` pulse each:
  - 'W',0x10,0x55 with NUM_REGS=16
  - 'R',0xFF
  - lone 0x41
- Partial frame and timeout:
  - Stimulus: 'W',0x02 then silence for TIMEOUT_CYCLES cycles, then 'R',0x02.
  - Required: `frame_err` pulses after TIMEOUT_CYCLES-1 empty cycles; no byte pushed for the partial frame; read returns 0x00.
- Response backpressure: hold `tx_full`=1 during a read response for 50 cycles → FSM holds SEND, `rd_uart`=0 although `rx_empty`=0, `w_data` stable; a single push occurs on release.
- Reset mid-frame: assert `reset_n`=0 for one cycle after 'W',0x01 → no response; registers 0x00; next frame 'R',0x01 returns 0x00.
